// File: rtl/cas_sel_arbiter_if.sv
// rtl/cas_sel_arbiter_if.sv - request/grant/select bundle between the requesters, the arbiter and the 4-way select mux
interface cas_sel_arbiter_if #(
   parameter int SEL_W = 260
);
   logic [3:0]       req;
   logic [3:0]       gnt;
   logic [1:0]       gnt_idx;
   logic [SEL_W-1:0] sel;
   logic             sel_vld;

   // arbiter side
   modport master (
      input  req,
      output gnt, gnt_idx, sel, sel_vld
   );

   // requester / mux side
   modport slave (
      output req,
      input  gnt, gnt_idx, sel, sel_vld
   );
endinterface

// File: rtl/cas_sel_arbiter.sv
// rtl/cas_sel_arbiter.sv - round-robin grant and select sequencer for the 4-way wide-select mux (option macro CAS_SEL_IDLE_DEFA_EN)
module cas_sel_arbiter #(
   parameter int SEL_W    = 260,
   parameter int HOLD_CYC = 4,
   parameter int CNT_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cas_sel_arbiter_if.master       io_arb
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

`ifdef CAS_SEL_IDLE_DEFA_EN
   // all-ones matches no mux case item, so the mux holds while nobody is granted
   localparam logic [SEL_W-1:0] RST_SEL = '1;
`else
   localparam logic [SEL_W-1:0] RST_SEL = '0;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

   state_t           r_state, w_state;
   logic [3:0]       r_gnt, w_gnt;
   logic [1:0]       r_gnt_idx, w_gnt_idx;
   logic [SEL_W-1:0] r_sel, w_sel;
   logic             r_sel_vld, w_sel_vld;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [1:0]       r_last, w_last;
   logic [1:0]       w_win;
   logic             w_any;
   logic [SEL_W-1:0] w_code;
   logic [SEL_W-1:0] w_off_sel;

   // round-robin search starting one past the last granted source
   always_comb begin
      logic [1:0] c;
      w_win = r_last;
      w_any = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         c = r_last + 2'(k);
         if (!w_any && io_arb.req[c]) begin
            w_win = c;
            w_any = 1'b1;
         end
      end
   end

   // select code of the winner, zero-extended to the bus width
   always_comb begin
      w_code = '0;
      case (w_win)
         2'd0:    w_code[15:0] = 16'h0000;
         2'd1:    w_code[15:0] = 16'h000F;
         2'd2:    w_code[15:0] = 16'h00FF;
         default: w_code[15:0] = 16'hFFFF;
      endcase
`ifdef CAS_SEL_IDLE_DEFA_EN
      w_off_sel = '1;
`else
      w_off_sel = r_sel;
`endif
   end

   // next state and next registered outputs
   always_comb begin
      w_state   = r_state;
      w_gnt     = r_gnt;
      w_gnt_idx = r_gnt_idx;
      w_sel     = r_sel;
      w_sel_vld = r_sel_vld;
      w_cnt     = r_cnt;
      w_last    = r_last;
      case (r_state)
         S_GRANT: begin
            if (!io_arb.req[r_gnt_idx] || (r_cnt == CNT_LAST)) begin
               w_state   = S_GAP;
               w_gnt     = 4'b0000;
               w_sel_vld = 1'b0;
               w_sel     = w_off_sel;
               w_cnt     = '0;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            // IDLE and the single GAP cycle arbitrate identically
            if (w_any) begin
               w_state   = S_GRANT;
               w_gnt     = 4'b0001 << w_win;
               w_gnt_idx = w_win;
               w_sel     = w_code;
               w_sel_vld = 1'b1;
               w_cnt     = '0;
               w_last    = w_win;
            end else begin
               w_state = S_IDLE;
            end
         end
      endcase
   end

   // state and output registers; reset drops the grant immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= 4'b0000;
         r_gnt_idx <= 2'd0;
         r_sel     <= RST_SEL;
         r_sel_vld <= 1'b0;
         r_cnt     <= '0;
         r_last    <= 2'd3;
      end else begin
         r_state   <= w_state;
         r_gnt     <= w_gnt;
         r_gnt_idx <= w_gnt_idx;
         r_sel     <= w_sel;
         r_sel_vld <= w_sel_vld;
         r_cnt     <= w_cnt;
         r_last    <= w_last;
      end
   end

   assign io_arb.gnt     = r_gnt;
   assign io_arb.gnt_idx = r_gnt_idx;
   assign io_arb.sel     = r_sel;
   assign io_arb.sel_vld = r_sel_vld;

endmodule

// File: tb/tb_cas_sel_arbiter.sv
// tb/tb_cas_sel_arbiter.sv - table-driven bench for cas_sel_arbiter
module tb_cas_sel_arbiter;

   localparam int SEL_W = 260;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic [1:0]  idx;
      logic [15:0] code;
      logic        vld;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];

   cas_sel_arbiter_if #(.SEL_W(SEL_W)) bus ();

   cas_sel_arbiter #(
      .SEL_W    (SEL_W),
      .HOLD_CYC (4),
      .CNT_W    (3)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_arb (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [SEL_W-1:0] exp_sel(logic [15:0] code, logic vld);
      exp_sel = {{(SEL_W-16){1'b0}}, code};
`ifdef CAS_SEL_IDLE_DEFA_EN
      if (!vld) exp_sel = '1;
`endif
   endfunction

   function automatic logic [15:0] code_of(logic [1:0] idx);
      case (idx)
         2'd0:    code_of = 16'h0000;
         2'd1:    code_of = 16'h000F;
         2'd2:    code_of = 16'h00FF;
         default: code_of = 16'hFFFF;
      endcase
   endfunction

   task automatic chk(string name, logic [SEL_W-1:0] act, logic [SEL_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(logic rst, logic [3:0] req, logic [3:0] gnt, logic [1:0] idx,
                      logic [15:0] code, logic vld);
      vec_t v;
      v.rst = rst; v.req = req; v.gnt = gnt; v.idx = idx; v.code = code; v.vld = vld;
      tbl.push_back(v);
   endtask

   task automatic chk_inv(string tag);
      chk({tag, " onehot0"}, SEL_W'($onehot0(bus.gnt)), SEL_W'(1));
      chk({tag, " vld==|gnt"}, SEL_W'(bus.sel_vld), SEL_W'(|bus.gnt));
      if (bus.sel_vld)
         chk({tag, " sel_vs_idx"}, bus.sel, {{(SEL_W-16){1'b0}}, code_of(bus.gnt_idx)});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      // 4'b1111 from reset: rotation 0,1,2,3,0 with 4-cycle grants and 1-cycle gaps
      repeat (4) add(0, 4'hF, 4'b0001, 2'd0, 16'h0000, 1);
      add(0, 4'hF, 4'b0000, 2'd0, 16'h0000, 0);
      repeat (4) add(0, 4'hF, 4'b0010, 2'd1, 16'h000F, 1);
      add(0, 4'hF, 4'b0000, 2'd1, 16'h000F, 0);
      repeat (4) add(0, 4'hF, 4'b0100, 2'd2, 16'h00FF, 1);
      add(0, 4'hF, 4'b0000, 2'd2, 16'h00FF, 0);
      repeat (4) add(0, 4'hF, 4'b1000, 2'd3, 16'hFFFF, 1);
      add(0, 4'hF, 4'b0000, 2'd3, 16'hFFFF, 0);
      add(0, 4'hF, 4'b0001, 2'd0, 16'h0000, 1);
      // synchronous-looking reset row (asserted at negedge)
      add(1, 4'h0, 4'b0000, 2'd0, 16'h0000, 0);
      // 4'b0100 held 10 cycles: grant 4, gap, re-grant 4, gap, then idle
      repeat (4) add(0, 4'h4, 4'b0100, 2'd2, 16'h00FF, 1);
      add(0, 4'h4, 4'b0000, 2'd2, 16'h00FF, 0);
      repeat (4) add(0, 4'h4, 4'b0100, 2'd2, 16'h00FF, 1);
      add(0, 4'h4, 4'b0000, 2'd2, 16'h00FF, 0);
      add(0, 4'h0, 4'b0000, 2'd2, 16'h00FF, 0);
      // 4'b0010 for 2 cycles: short grant, gap, idle, gnt_idx holds 1
      repeat (2) add(0, 4'h2, 4'b0010, 2'd1, 16'h000F, 1);
      add(0, 4'h0, 4'b0000, 2'd1, 16'h000F, 0);
      add(0, 4'h0, 4'b0000, 2'd1, 16'h000F, 0);
      // set last=0 with a 1-cycle grant of idx0
      add(0, 4'h1, 4'b0001, 2'd0, 16'h0000, 1);
      add(0, 4'h0, 4'b0000, 2'd0, 16'h0000, 0);
      add(0, 4'h0, 4'b0000, 2'd0, 16'h0000, 0);
      // req[0] and req[3] with last=0: idx3 first, then idx0
      repeat (4) add(0, 4'h9, 4'b1000, 2'd3, 16'hFFFF, 1);
      add(0, 4'h9, 4'b0000, 2'd3, 16'hFFFF, 0);
      repeat (4) add(0, 4'h9, 4'b0001, 2'd0, 16'h0000, 1);
      add(0, 4'h0, 4'b0000, 2'd0, 16'h0000, 0);
      add(0, 4'h0, 4'b0000, 2'd0, 16'h0000, 0);

      rst_n   = 1'b0;
      bus.req = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset gnt", SEL_W'(bus.gnt), SEL_W'(0));
      chk("reset idx", SEL_W'(bus.gnt_idx), SEL_W'(0));
      chk("reset vld", SEL_W'(bus.sel_vld), SEL_W'(0));
      chk("reset sel", bus.sel, exp_sel(16'h0000, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n   = !tbl[i].rst;
         bus.req = tbl[i].req;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d gnt", i), SEL_W'(bus.gnt), SEL_W'(tbl[i].gnt));
         chk($sformatf("row%0d idx", i), SEL_W'(bus.gnt_idx), SEL_W'(tbl[i].idx));
         chk($sformatf("row%0d vld", i), SEL_W'(bus.sel_vld), SEL_W'(tbl[i].vld));
         chk($sformatf("row%0d sel", i), bus.sel, exp_sel(tbl[i].code, tbl[i].vld));
         chk_inv($sformatf("row%0d", i));
      end

      // async reset in the middle of a grant, then restart with last=3
      @(negedge clk);
      rst_n   = 1'b0;
      bus.req = 4'h0;
      @(negedge clk);
      rst_n   = 1'b1;
      bus.req = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("pre-reset gnt", SEL_W'(bus.gnt), SEL_W'(4'b0001));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async gnt", SEL_W'(bus.gnt), SEL_W'(0));
      chk("async vld", SEL_W'(bus.sel_vld), SEL_W'(0));
      chk("async sel", bus.sel, exp_sel(16'h0000, 1'b0));
      @(negedge clk);
      rst_n   = 1'b1;
      bus.req = 4'h9;
      @(posedge clk);
      #1;
      chk("restart gnt", SEL_W'(bus.gnt), SEL_W'(4'b0001));
      chk("restart idx", SEL_W'(bus.gnt_idx), SEL_W'(0));
      chk("restart sel", bus.sel, exp_sel(16'h0000, 1'b1));
      chk_inv("restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
